// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared RV32 core constants and types: datapath width, address
//            type and instruction alignment masks.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [1:0] ALIGN_MASK_32 = 2'b11;
    localparam logic [1:0] ALIGN_MASK_16 = 2'b01;

endpackage : core_pkg
`default_nettype wire

// File: rtl/pc_target_adder.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_adder
// Brief    : Pure combinational XLEN-bit adder with unsigned carry-out and
//            two's-complement overflow detection.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_adder
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum,
    output logic            carry,
    output logic            ovf
);

    logic [XLEN:0] w_wide_sum;

    // Widen by one bit so the carry-out falls out of the same add.
    always_comb begin
        w_wide_sum = {1'b0, a} + {1'b0, b};
    end

    assign sum   = w_wide_sum[XLEN-1:0];
    assign carry = w_wide_sum[XLEN];

    // Signed overflow: operands share a sign and the result's sign differs.
    assign ovf   = (a[XLEN-1] == b[XLEN-1]) && (w_wide_sum[XLEN-1] != a[XLEN-1]);

endmodule : pc_target_adder
`default_nettype wire

// File: rtl/pc_target_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_unit
// Brief    : Execute-stage branch/jump target generator. Forms PC + ImmExt
//            combinationally, flags carry, overflow and misalignment, and
//            keeps a registered copy of the last captured target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_unit
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int C_EXT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            TargetValid,
    output logic [XLEN-1:0] PCTarget,
    output logic            PCTargetCarry,
    output logic            PCTargetOvf,
    output logic            PCTargetMisaligned,
    output logic [XLEN-1:0] PCTargetQ,
    output logic            MisalignedQ,
    output logic            ValidQ
);

    logic [XLEN-1:0] w_target;
    logic            w_carry;
    logic            w_ovf;
    logic [1:0]      w_align_mask;
    logic            w_misaligned;

    logic [XLEN-1:0] r_target;
    logic            r_misaligned;
    logic            r_valid;

    pc_target_adder #(
        .XLEN (XLEN)
    ) u_adder (
        .a     (PC),
        .b     (ImmExt),
        .sum   (w_target),
        .carry (w_carry),
        .ovf   (w_ovf)
    );

    // Compressed ISA relaxes alignment to halfwords; otherwise words.
    generate
        if (C_EXT != 0) begin : g_align_16
            assign w_align_mask = ALIGN_MASK_16;
        end else begin : g_align_32
            assign w_align_mask = ALIGN_MASK_32;
        end
    endgenerate

    // Flag only; the target itself is never modified.
    always_comb begin
        w_misaligned = |(w_target[1:0] & w_align_mask);
    end

    // Capture target and flag on a strobe; ValidQ tracks the strobe each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target     <= '0;
            r_misaligned <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= TargetValid;
            if (TargetValid) begin
                r_target     <= w_target;
                r_misaligned <= w_misaligned;
            end
        end
    end

    assign PCTarget           = w_target;
    assign PCTargetCarry      = w_carry;
    assign PCTargetOvf        = w_ovf;
    assign PCTargetMisaligned = w_misaligned;
    assign PCTargetQ          = r_target;
    assign MisalignedQ        = r_misaligned;
    assign ValidQ             = r_valid;

endmodule : pc_target_unit
`default_nettype wire

// File: tb/tb_pc_target_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_target_unit
// Brief    : Directed self-checking bench for pc_target_unit, one instance per
//            alignment mode sharing the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_target_unit;
    import core_pkg::*;

    logic  clk;
    logic  rst_n;
    addr_t PC;
    addr_t ImmExt;
    logic  TargetValid;

    addr_t w_tgt0, w_tgt1, w_q0, w_q1;
    logic  w_cy0, w_cy1, w_ov0, w_ov1, w_mis0, w_mis1;
    logic  w_misq0, w_misq1, w_vq0, w_vq1;

    int errors = 0;
    int checks = 0;

    pc_target_unit #(.XLEN(32), .C_EXT(0)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .PC                 (PC),
        .ImmExt             (ImmExt),
        .TargetValid        (TargetValid),
        .PCTarget           (w_tgt0),
        .PCTargetCarry      (w_cy0),
        .PCTargetOvf        (w_ov0),
        .PCTargetMisaligned (w_mis0),
        .PCTargetQ          (w_q0),
        .MisalignedQ        (w_misq0),
        .ValidQ             (w_vq0)
    );

    pc_target_unit #(.XLEN(32), .C_EXT(1)) dut_c (
        .clk                (clk),
        .rst_n              (rst_n),
        .PC                 (PC),
        .ImmExt             (ImmExt),
        .TargetValid        (TargetValid),
        .PCTarget           (w_tgt1),
        .PCTargetCarry      (w_cy1),
        .PCTargetOvf        (w_ov1),
        .PCTargetMisaligned (w_mis1),
        .PCTargetQ          (w_q1),
        .MisalignedQ        (w_misq1),
        .ValidQ             (w_vq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The strobe must never be unknown outside reset.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown(TargetValid)) else begin
                errors++;
                $error("FAIL tv_known: observed=%b expected=0/1", TargetValid);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag, input logic [31:0] tgt,
                              input logic cy, input logic ov,
                              input logic mis0, input logic mis1);
        check({tag, "_tgt"},   w_tgt0, tgt);
        check({tag, "_tgt_c"}, w_tgt1, tgt);
        check({tag, "_cy"},    {31'd0, w_cy0}, {31'd0, cy});
        check({tag, "_ov"},    {31'd0, w_ov0}, {31'd0, ov});
        check({tag, "_mis"},   {31'd0, w_mis0}, {31'd0, mis0});
        check({tag, "_mis_c"}, {31'd0, w_mis1}, {31'd0, mis1});
    endtask

    task automatic check_q(input string tag, input logic [31:0] q,
                           input logic mis0, input logic mis1, input logic v);
        check({tag, "_q"},     w_q0, q);
        check({tag, "_q_c"},   w_q1, q);
        check({tag, "_misq"},  {31'd0, w_misq0}, {31'd0, mis0});
        check({tag, "_misq_c"},{31'd0, w_misq1}, {31'd0, mis1});
        check({tag, "_vq"},    {31'd0, w_vq0}, {31'd0, v});
        check({tag, "_vq_c"},  {31'd0, w_vq1}, {31'd0, v});
    endtask

    initial begin
        rst_n       = 1'b0;
        TargetValid = 1'b0;
        PC          = 32'h0000_0000;
        ImmExt      = 32'h0000_0004;
        #1;
        check_q("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        // Combinational path is live during reset.
        check_comb("v0", 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0);

        PC = 32'h0000_0010; ImmExt = 32'h0000_0008; #1;
        check_comb("v1", 32'h0000_0018, 1'b0, 1'b0, 1'b0, 1'b0);

        PC = 32'h1000_0000; ImmExt = 32'hFFFF_FFFC; #1;
        check_comb("v2", 32'h0FFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);

        PC = 32'h7FFF_FFFF; ImmExt = 32'h0000_0001; #1;
        check_comb("v3", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

        PC = 32'h0000_0100; ImmExt = 32'h0000_0002; #1;
        check_comb("v4", 32'h0000_0102, 1'b0, 1'b0, 1'b1, 1'b0);

        PC = 32'h0000_0100; ImmExt = 32'h0000_0001; #1;
        check_comb("v5", 32'h0000_0101, 1'b0, 1'b0, 1'b1, 1'b1);

        // Negative-overflow and full wrap to zero.
        PC = 32'h8000_0000; ImmExt = 32'h8000_0000; #1;
        check_comb("v6", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Edges held while in reset leave the registers at zero.
        TargetValid = 1'b1;
        @(posedge clk); #1;
        check_q("in_reset", 32'h0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        TargetValid = 1'b0;
        rst_n       = 1'b1;
        PC = 32'h0000_0010; ImmExt = 32'h0000_0008;
        @(posedge clk); #1;
        check_q("idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // Single capture.
        @(negedge clk);
        TargetValid = 1'b1;
        @(posedge clk); #1;
        check_q("cap1", 32'h0000_0018, 1'b0, 1'b0, 1'b1);

        // Strobe low: hold target, ValidQ drops.
        @(negedge clk);
        TargetValid = 1'b0;
        PC = 32'h0000_0100; ImmExt = 32'h0000_0002;
        @(posedge clk); #1;
        check_q("hold", 32'h0000_0018, 1'b0, 1'b0, 1'b0);

        // Misaligned capture, then back-to-back aligned capture.
        @(negedge clk);
        TargetValid = 1'b1;
        @(posedge clk); #1;
        check_q("cap_mis", 32'h0000_0102, 1'b1, 1'b0, 1'b1);

        @(negedge clk);
        PC = 32'h0000_0010; ImmExt = 32'h0000_0008;
        @(posedge clk); #1;
        check_q("b2b", 32'h0000_0018, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with a strobe pending.
        #3;
        rst_n = 1'b0;
        #1;
        check_q("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        check("async_rst_tgt", w_tgt0, 32'h0000_0018);

        @(posedge clk); #1;
        check_q("rst_edge", 32'h0, 1'b0, 1'b0, 1'b0);

        // Release with strobe low: nothing captured.
        @(negedge clk);
        rst_n       = 1'b1;
        TargetValid = 1'b0;
        @(posedge clk); #1;
        check_q("post_rst", 32'h0, 1'b0, 1'b0, 1'b0);

        // First strobe after release captures.
        @(negedge clk);
        PC = 32'h0000_0200; ImmExt = 32'hFFFF_FFFE;
        TargetValid = 1'b1;
        @(posedge clk); #1;
        check_q("recap", 32'h0000_01FE, 1'b1, 1'b0, 1'b1);

        @(negedge clk);
        TargetValid = 1'b0;
        #20;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_target_unit
`default_nettype wire
